// File: rtl/wb_dest_pipe_pkg.sv
// Shared constants for write-back destination decode.
// Op code layout and default special register addresses.
package wb_dest_pipe_pkg;

  localparam int WB_ADDR_OP_NOP = 0;
  localparam int FIELD_BASE     = 1;

  localparam logic [3:0] SPEC_T  = 4'd8;
  localparam logic [3:0] SPEC_SP = 4'd9;
  localparam logic [3:0] SPEC_IH = 4'd10;
  localparam logic [3:0] SPEC_RA = 4'd11;

  localparam logic [15:0] SPECIAL_ADDR_DEF =
    {SPEC_RA, SPEC_IH, SPEC_SP, SPEC_T};

  function automatic int special_base(
    input int num_field
  );
    return FIELD_BASE + num_field;
  endfunction

  function automatic int sel_width(
    input int depth
  );
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-stage match encoder for one source operand.
// Lowest matching stage index wins; sel is 0 on a miss.
module wb_fwd_match
  import wb_dest_pipe_pkg::*;
#(
  parameter int DEPTH       = 3,
  parameter int REG_ADDR_W  = 4,
  parameter int ZERO_REG_EN = 0,
  parameter int SEL_W       = sel_width(DEPTH)
) (
  input  logic [DEPTH*REG_ADDR_W-1:0] stage_addr,
  input  logic [DEPTH-1:0]            stage_vld,
  input  logic [REG_ADDR_W-1:0]       rd_addr,
  output logic                        hit,
  output logic [SEL_W-1:0]            sel
);

  logic rd_zero;

  assign rd_zero = (ZERO_REG_EN != 0) &&
                   (rd_addr == '0);

  // Scan oldest to youngest so the youngest overwrites.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stage_vld[k] && !rd_zero &&
          stage_addr[k*REG_ADDR_W +: REG_ADDR_W]
            == rd_addr) begin
        hit = 1'b1;
        sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_dest_pipe.sv
// Write-back destination decode and EX..WB pipeline.
// Drives the regfile write port and operand forward selects.
module wb_dest_pipe
  import wb_dest_pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter int NUM_FIELD   = 3,
  parameter int NUM_SPECIAL = 4,
  parameter logic [NUM_SPECIAL*REG_ADDR_W-1:0]
    SPECIAL_ADDR = SPECIAL_ADDR_DEF,
  parameter int DEPTH       = 3,
  parameter int ZERO_REG_EN = 0,
  parameter int OP_W  = $clog2(1 + NUM_FIELD + NUM_SPECIAL),
  parameter int SEL_W = sel_width(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [OP_W-1:0]                wb_addr_op,
  input  logic [NUM_FIELD*REG_ADDR_W-1:0] field_addr,
  input  logic [REG_ADDR_W-1:0]          rd_addr_a,
  input  logic [REG_ADDR_W-1:0]          rd_addr_b,
  output logic [DEPTH*REG_ADDR_W-1:0]    stage_addr,
  output logic [DEPTH-1:0]               stage_vld,
  output logic                           fwd_hit_a,
  output logic [SEL_W-1:0]               fwd_sel_a,
  output logic                           fwd_hit_b,
  output logic [SEL_W-1:0]               fwd_sel_b,
  output logic [REG_ADDR_W-1:0]          wb_addr,
  output logic                           wb_en,
  output logic                           illegal_op
);

  localparam int SB  = special_base(NUM_FIELD);
  localparam int ILL = SB + NUM_SPECIAL;
  localparam int W   = REG_ADDR_W;

  int           op_i;
  logic [W-1:0] dec_addr;
  logic         dec_vld;
  logic         dec_ill;

  always_comb begin
    dec_addr = '0;
    dec_vld  = 1'b0;
    dec_ill  = 1'b0;
    op_i     = int'(wb_addr_op);
    unique case (1'b1)
      (op_i >= ILL): begin
        dec_ill = 1'b1;
      end
      (op_i >= SB && op_i < ILL): begin
        dec_addr = SPECIAL_ADDR[(op_i-SB)*W +: W];
        dec_vld  = 1'b1;
      end
      (op_i >= FIELD_BASE && op_i < SB): begin
        dec_addr =
          field_addr[(op_i-FIELD_BASE)*W +: W];
        dec_vld  = 1'b1;
      end
      default: begin
        dec_vld = 1'b0;
      end
    endcase
    if (ZERO_REG_EN != 0 && dec_addr == '0)
      dec_vld = 1'b0;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [W-1:0] addr_q;
    logic         vld_q;

    if (k == 0) begin : g_head
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          addr_q <= '0;
          vld_q  <= 1'b0;
        end else if (flush) begin
          vld_q  <= 1'b0;
        end else if (!stall) begin
          addr_q <= dec_addr;
          vld_q  <= dec_vld;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          addr_q <= '0;
          vld_q  <= 1'b0;
        end else if (!stall) begin
          addr_q <= g_stage[k-1].addr_q;
          vld_q  <= g_stage[k-1].vld_q;
        end
      end
    end

    assign stage_addr[k*W +: W] = addr_q;
    assign stage_vld[k]         = vld_q;
  end

  // Illegal codes are discarded along with the rest on a pure stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      illegal_op <= 1'b0;
    else if (dec_ill && !(stall && !flush))
      illegal_op <= 1'b1;
  end

  logic [W-1:0] wb_stage_addr;
  logic [W-1:0] wb_last_q;

  assign wb_stage_addr = stage_addr[(DEPTH-1)*W +: W];
  assign wb_en         = stage_vld[DEPTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wb_last_q <= '0;
    else if (wb_en)
      wb_last_q <= wb_stage_addr;
  end

  assign wb_addr = wb_en ? wb_stage_addr : wb_last_q;

  wb_fwd_match #(
    .DEPTH       (DEPTH),
    .REG_ADDR_W  (REG_ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN),
    .SEL_W       (SEL_W)
  ) u_fwd_a (
    .stage_addr (stage_addr),
    .stage_vld  (stage_vld),
    .rd_addr    (rd_addr_a),
    .hit        (fwd_hit_a),
    .sel        (fwd_sel_a)
  );

  wb_fwd_match #(
    .DEPTH       (DEPTH),
    .REG_ADDR_W  (REG_ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN),
    .SEL_W       (SEL_W)
  ) u_fwd_b (
    .stage_addr (stage_addr),
    .stage_vld  (stage_vld),
    .rd_addr    (rd_addr_b),
    .hit        (fwd_hit_b),
    .sel        (fwd_sel_b)
  );

endmodule
